// File: rtl/mult_div.sv
// mult_div: iterative 32x32 multiply / divide unit that owns the MIPS HI/LO
// register pair. Shift-add multiply and restoring divide run on operand
// magnitudes for 32 cycles. A final FIX cycle applies the sign correction
// and commits the result.
package mult_div_pkg;
  typedef logic [5:0] funct_t;
  localparam funct_t FUNCT_MFHI  = 6'h10;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MFLO  = 6'h12;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1A;
  localparam funct_t FUNCT_DIVU  = 6'h1B;
endpackage

module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  funct_t      fncode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state, w_next;
  logic        r_is_div, r_neg_q, r_neg_r, r_bzero, r_done;
  logic [31:0] r_b, r_rem, r_q, r_hi, r_lo;
  logic [4:0]  r_cnt;

  logic        w_is_mul, w_is_div, w_signed, w_go;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_sum, w_shift, w_diff;
  logic [63:0] w_prod, w_prod_fix;
  logic [31:0] w_quo_fix, w_rem_fix;

  // Operation decode and operand magnitudes.
  always_comb begin
    w_is_mul = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU);
    w_is_div = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
    w_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    w_go     = (r_state == S_IDLE) && start && (w_is_mul || w_is_div);
    w_a_mag  = (w_signed && a[31]) ? (~a + 32'd1) : a;
    w_b_mag  = (w_signed && b[31]) ? (~b + 32'd1) : b;
  end

  // Per-iteration datapath and the final sign correction.
  // Multiply keeps {r_rem,r_q} as the shifting product with the multiplier in r_q.
  // Divide keeps the partial remainder in r_rem and shifts the dividend out of r_q.
  always_comb begin
    w_sum      = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : 33'd0);
    w_shift    = {r_rem, r_q[31]};
    w_diff     = w_shift - {1'b0, r_b};
    w_prod     = {r_rem, r_q};
    w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;
    w_quo_fix  = r_bzero ? '1 : (r_neg_q ? (~r_q + 32'd1) : r_q);
    w_rem_fix  = r_neg_r ? (~r_rem + 32'd1) : r_rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, iterations, HI/LO writes and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_signed && (a[31] ^ b[31]);
            r_neg_r  <= w_signed && w_is_div && a[31];
            r_bzero  <= w_is_div && (b == '0);
            r_b      <= w_is_div ? w_b_mag : w_a_mag;
            r_q      <= w_is_div ? w_a_mag : w_b_mag;
            r_rem    <= '0;
            r_cnt    <= '0;
          end else if (start && (fncode == FUNCT_MTHI)) begin
            r_hi <= a;
          end else if (start && (fncode == FUNCT_MTLO)) begin
            r_lo <= a;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            if (!w_diff[32]) begin
              r_rem <= w_diff[31:0];
              r_q   <= {r_q[30:0], 1'b1};
            end else begin
              r_rem <= w_shift[31:0];
              r_q   <= {r_q[30:0], 1'b0};
            end
          end else begin
            r_rem <= w_sum[32:1];
            r_q   <= {w_sum[0], r_q[31:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: randomized and directed stimulus for mult_div. The DUT is
// checked every cycle against a transaction-level model of HI/LO, busy and
// done. A few literal expectations pin the model itself.
module tb_mult_div;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  funct_t      fncode = FUNCT_MFHI;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mult_div dut (
    .clk(clk), .reset(reset), .start(start), .fncode(fncode),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: a result is computed with plain arithmetic when the
  // operation is accepted, then held back for 33 cycles.
  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0;

  function automatic void compute(input funct_t f, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl);
    longint          sx, sy, q, r;
    longint unsigned up;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0;
    rl = '0;
    case (f)
      FUNCT_MULTU: begin
        up = longint'(x) * longint'(y);
        p  = up;
        rh = p[63:32];
        rl = p[31:0];
      end
      FUNCT_MULT: begin
        p  = sx * sy;
        rh = p[63:32];
        rl = p[31:0];
      end
      FUNCT_DIVU: begin
        if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
        else begin rl = x / y; rh = x % y; end
      end
      default: begin
        if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin rl = 32'h80000000; rh = 0; end
        else begin
          q = sx / sy;
          r = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_cnt = 0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
      end
    end else if (start) begin
      if (fncode == FUNCT_MTHI) m_hi = a;
      else if (fncode == FUNCT_MTLO) m_lo = a;
      else if (fncode == FUNCT_MULT || fncode == FUNCT_MULTU ||
               fncode == FUNCT_DIV  || fncode == FUNCT_DIVU) begin
        compute(fncode, a, b, p_hi, p_lo);
        m_cnt = 33;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // Drive one request for one cycle; caller is positioned at a negedge.
  task automatic issue(input funct_t f, input logic [31:0] x, input logic [31:0] y);
    start  = 1'b1;
    fncode = f;
    a      = x;
    b      = y;
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    fncode = funct_t'($urandom_range(0, 63));
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: done=0 required 1", nm);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  funct_t ops[10] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MULT,
                      FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO, FUNCT_MFHI, 6'h20};

  initial begin
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hi", hi, 32'h0);
      chk("idle_busy", {31'd0, busy}, 32'h0);
    end

    issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max");
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    issue(FUNCT_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_neg");
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    issue(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg");
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(FUNCT_DIVU, 32'd100, 32'd0);
    wait_done("divu_zero");
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'h00000064);

    issue(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf");
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    issue(FUNCT_MTHI, 32'h12345678, 32'h0);
    chk("mthi", hi, 32'h12345678);
    issue(FUNCT_MTLO, 32'hCAFEF00D, 32'h0);
    chk("mtlo", lo, 32'hCAFEF00D);

    // DIVU with a second start at cycle 10 that must be ignored.
    issue(FUNCT_DIVU, 32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    issue(FUNCT_MULTU, 32'd3, 32'd3);
    wait_done("divu_busy");
    chk("divu_q", lo, 32'd142);
    chk("divu_r", hi, 32'd6);

    // Reset mid-RUN discards the operation.
    issue(FUNCT_MULTU, 32'd7, 32'd9);
    repeat (14) @(negedge clk);
    pulse_reset();
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    issue(FUNCT_MULTU, 32'd7, 32'd9);
    wait_done("multu_7x9");
    chk("m79_lo", lo, 32'd63);
    chk("m79_hi", hi, 32'd0);

    // Reset and start together: reset wins.
    reset = 1'b1;
    issue(FUNCT_MULT, 32'd5, 32'd5);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {31'd0, busy}, 32'h0);

    // Randomized traffic; back-to-back starts land in the done cycle.
    for (int n = 0; n < 60; n++) begin
      funct_t      f;
      logic [31:0] x, y;
      f = ops[$urandom_range(0, 9)];
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = $urandom_range(1, 15);
        3: x = $urandom_range(0, 1000);
        default: ;
      endcase
      issue(f, x, y);
      if (f == FUNCT_MULT || f == FUNCT_MULTU || f == FUNCT_DIV || f == FUNCT_DIVU) begin
        if ($urandom_range(0, 7) == 0) begin
          repeat ($urandom_range(1, 30)) @(negedge clk);
          pulse_reset();
        end else begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            issue(ops[$urandom_range(0, 9)], $urandom, $urandom);
          end
          wait_done("rand_op");
        end
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Iterative multiply/divide unit that owns the MIPS HI/LO register pair. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and supplies HI/LO for MFHI/MFLO. It sits alongside the single-cycle ALU in the execute stage. It consumes the same `funct_t` codes from `package.v` and the same 32-bit `a`/`b` operand buses. It is multi-cycle: a start/busy/done handshake lets control stall the pipeline on HI/LO hazards.

## Interface
Parameters: none; all widths are fixed at 32 by the ISA.

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
- start  input  1  request; sampled only while busy=0
- fncode  input  funct_t  operation; FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO are honoured
- a  input  32  rs operand: multiplicand/dividend, or MTHI/MTLO source
- b  input  32  rt operand: multiplier/divisor
- busy  output  1  high while an iterative operation is in flight
- done  output  1  one-cycle pulse when a MULT/DIV result has been committed to hi/lo
- hi  output  32  HI register; registered
- lo  output  32  LO register; registered

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Mult/div code: latch operands and signedness, counter := 0, go to RUN.
  - FUNCT_MTHI: hi := a. FUNCT_MTLO: lo := a. Stay in IDLE, no done pulse.
  - Any other code: ignored.
- RUN: one shift-add (mult) or restoring shift-subtract (div) iteration per cycle on operand magnitudes. Counter increments; after iteration 31 (counter=31), go to FIX.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
- Multiply, unsigned: {hi,lo} := a*b as a 64-bit product. Signed: 64-bit two's-complement product.
- Divide, unsigned: lo := a/b, hi := a%b.
- Divide, signed: quotient truncates toward zero. Remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- Divide by zero, either signedness: lo := 0xFFFFFFFF, hi := a. Full latency still applies.
- hi/lo hold their values except on FIX commit, MTHI/MTLO, or reset.
- start while busy=1 is ignored; operands and fncode do not need to be held after the start cycle.

## Timing
- Reset (any state, including mid-RUN): next cycle state=IDLE, busy=0, done=0, hi=0, lo=0. The in-flight operation is discarded.
- start sampled at rising edge N (mult/div):
  - busy=1 from after edge N until edge N+33.
  - RUN occupies edges N+1..N+32; FIX is evaluated at edge N+33.
  - hi/lo show the result and done=1 during the cycle after edge N+33; busy=0 in that cycle.
- Total latency is 33 cycles from start to result; a new start may be accepted in the done cycle.
- MTHI/MTLO sampled at edge N: hi/lo updated after edge N (1-cycle latency); busy stays 0.
- Reset and start asserted together: reset wins.

## Test plan
- Reset, then idle 5 cycles -> hi=0, lo=0, busy=0, done=0 throughout.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00000064. Signed DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, next cycle MTLO a=0xCAFEF00D -> hi/lo update one cycle after each start; busy never rises. Then start DIVU, and assert a second start with MULTU at cycle 10 -> second start ignored; DIVU result committed.
- Start MULTU 7*9, assert reset at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse; a fresh MULTU 7*9 then gives lo=63, hi=0.
